// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file writeback block.
// DEPTH and XLEN are set here so the entry, pointer and count types stay consistent.
package rf_wb_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;   // power of two, >= 2
  localparam int unsigned WB_PTR_W = $clog2(DEPTH);
  localparam int unsigned WB_CNT_W = $clog2(DEPTH + 1);

  typedef logic [REG_AW-1:0]   reg_addr_t;
  typedef logic [WB_PTR_W-1:0] wb_ptr_t;
  typedef logic [WB_CNT_W-1:0] wb_cnt_t;

  typedef struct packed {
    logic             live;
    reg_addr_t        rd;
    logic [XLEN-1:0]  val;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(reg_addr_t a);
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/rf_writeback_if.sv
// ALU/LSU result inputs and regfile write-port outputs of rf_writeback.
// Lookup signals exist only when RF_WB_BYPASS_EN is defined.
interface rf_writeback_if;
  import rf_wb_pkg::*;

  logic                alu_valid;
  reg_addr_t           alu_rd;
  logic [XLEN-1:0]     alu_val;
  logic                lsu_valid;
  logic                lsu_ready;
  reg_addr_t           lsu_rd;
  logic [XLEN-1:0]     lsu_val;
  reg_addr_t           rd;
  logic                rd_write_control;
  logic [XLEN-1:0]     rd_write_val;
  wb_cnt_t             pend_cnt;
  logic [NUM_REGS-1:0] busy_mask;
`ifdef RF_WB_BYPASS_EN
  reg_addr_t           fwd_rs;
  logic                fwd_hit;
  logic [XLEN-1:0]     fwd_val;

  modport master (
    output alu_valid, alu_rd, alu_val, lsu_valid, lsu_rd, lsu_val, fwd_rs,
    input  lsu_ready, rd, rd_write_control, rd_write_val, pend_cnt, busy_mask, fwd_hit, fwd_val
  );
  modport slave (
    input  alu_valid, alu_rd, alu_val, lsu_valid, lsu_rd, lsu_val, fwd_rs,
    output lsu_ready, rd, rd_write_control, rd_write_val, pend_cnt, busy_mask, fwd_hit, fwd_val
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_val, lsu_valid, lsu_rd, lsu_val,
    input  lsu_ready, rd, rd_write_control, rd_write_val, pend_cnt, busy_mask
  );
  modport slave (
    input  alu_valid, alu_rd, alu_val, lsu_valid, lsu_rd, lsu_val,
    output lsu_ready, rd, rd_write_control, rd_write_val, pend_cnt, busy_mask
  );
`endif
endinterface

// File: rtl/wb_queue.sv
// In-order circular queue of pending LSU results with kill-by-rd.
// Entry views are presented oldest-first; value view only with RF_WB_BYPASS_EN.
module wb_queue
  import rf_wb_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  reg_addr_t                  push_rd_i,
  input  logic [XLEN-1:0]            push_val_i,
  input  logic                       pop_i,
  input  logic                       kill_i,
  input  reg_addr_t                  kill_rd_i,
  output wb_entry_t                  head_o,
  output wb_cnt_t                    count_o,
  output logic [DEPTH-1:0]           live_o,
  output reg_addr_t [DEPTH-1:0]      rds_o
`ifdef RF_WB_BYPASS_EN
  ,
  output logic [DEPTH-1:0][XLEN-1:0] vals_o
`endif
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  wb_ptr_t               rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  wb_cnt_t               count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (kill_i && mem_q[i].rd == kill_rd_i) mem_d[i].live = 1'b0;
    end
    // Popped slots are cleared so only occupied entries can ever read as live.
    if (pop_i) begin
      mem_d[rd_ptr_q].live = 1'b0;
      rd_ptr_d             = rd_ptr_q + wb_ptr_t'(1);
    end
    if (push_i) begin
      mem_d[wr_ptr_q] = '{live: !(kill_i && push_rd_i == kill_rd_i), rd: push_rd_i,
                          val: push_val_i};
      wr_ptr_d        = wr_ptr_q + wb_ptr_t'(1);
    end
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + wb_cnt_t'(1);
      2'b01:   count_d = count_q - wb_cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    live_o = '0;
    rds_o  = '0;
`ifdef RF_WB_BYPASS_EN
    vals_o = '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      live_o[k] = mem_q[rd_ptr_q + wb_ptr_t'(k)].live;
      rds_o[k]  = mem_q[rd_ptr_q + wb_ptr_t'(k)].rd;
`ifdef RF_WB_BYPASS_EN
      vals_o[k] = mem_q[rd_ptr_q + wb_ptr_t'(k)].val;
`endif
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rf_writeback.sv
// Merges ALU and queued LSU results onto the single regfile write port (ALU first).
// Defining RF_WB_BYPASS_EN adds a combinational youngest-value lookup (fwd_rs/hit/val).
module rf_writeback
  import rf_wb_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  rf_writeback_if.slave  bus
);

  wb_entry_t             head;
  wb_cnt_t               count;
  logic [DEPTH-1:0]      q_live;
  reg_addr_t [DEPTH-1:0] q_rds;
`ifdef RF_WB_BYPASS_EN
  logic [DEPTH-1:0][XLEN-1:0] q_vals;
`endif

  logic            alu_wr, head_occ, head_wr, pop, push;
  reg_addr_t       rd_q, rd_d;
  logic            wc_q, wc_d;
  logic [XLEN-1:0] val_q, val_d;

  assign alu_wr        = bus.alu_valid && (bus.alu_rd != '0);
  assign head_occ      = (count != '0);
  assign head_wr       = head_occ && head.live && !alu_wr;
  // A killed head leaves regardless of ALU activity; a live one only when the port is free.
  assign pop           = head_occ && (!head.live || !alu_wr);
  assign bus.lsu_ready = i_rst && (count < wb_cnt_t'(DEPTH));
  assign push          = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != '0);

  wb_queue u_queue (
    .clk_i      (i_clk),
    .rst_ni     (i_rst),
    .push_i     (push),
    .push_rd_i  (bus.lsu_rd),
    .push_val_i (bus.lsu_val),
    .pop_i      (pop),
    .kill_i     (alu_wr),
    .kill_rd_i  (bus.alu_rd),
    .head_o     (head),
    .count_o    (count),
    .live_o     (q_live),
    .rds_o      (q_rds)
`ifdef RF_WB_BYPASS_EN
    ,
    .vals_o     (q_vals)
`endif
  );

  always_comb begin
    rd_d  = rd_q;
    val_d = val_q;
    wc_d  = 1'b0;
    if (alu_wr) begin
      rd_d  = bus.alu_rd;
      val_d = bus.alu_val;
      wc_d  = 1'b1;
    end else if (head_wr) begin
      rd_d  = head.rd;
      val_d = head.val;
      wc_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_q  <= '0;
      wc_q  <= 1'b0;
      val_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wc_q  <= wc_d;
      val_q <= val_d;
    end
  end

  assign bus.rd               = rd_q;
  assign bus.rd_write_control = wc_q;
  assign bus.rd_write_val     = val_q;
  assign bus.pend_cnt         = count;

  always_comb begin
    bus.busy_mask = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (q_live[k]) bus.busy_mask = bus.busy_mask | rd_onehot(q_rds[k]);
    end
  end

`ifdef RF_WB_BYPASS_EN
  // Scan oldest to youngest so the last match wins; the write port is older than the queue.
  always_comb begin
    bus.fwd_hit = 1'b0;
    bus.fwd_val = '0;
    if (wc_q && rd_q == bus.fwd_rs) begin
      bus.fwd_hit = 1'b1;
      bus.fwd_val = val_q;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (q_live[k] && q_rds[k] == bus.fwd_rs) begin
        bus.fwd_hit = 1'b1;
        bus.fwd_val = q_vals[k];
      end
    end
    if (!i_rst || bus.fwd_rs == '0) begin
      bus.fwd_hit = 1'b0;
      bus.fwd_val = '0;
    end
  end
`endif

endmodule
